// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_pkg
// Brief   : Shared width helpers for the synchronous FIFO and its storage.
// Revision: 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Address width needed to index DEPTH storage words.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Pointers carry one extra wrap bit above the address bits.
    // The level counter uses the same width, so it can hold 0..DEPTH.
    function automatic int ptr_w(input int depth);
        return addr_w(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_sdp_ram_ra.sv
`default_nettype none
// ============================================================================
// Module  : SdpRamRa
// Brief   : Simple dual-port RAM, synchronous write, asynchronous read.
// Revision: 1.0 - initial release
// ============================================================================
module SdpRamRa
    import fifo_pkg::*;
#(
    parameter int WORDS = 16,
    parameter int DW    = 8
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [addr_w(WORDS)-1:0] i_waddr,
    input  logic [DW-1:0]            i_wdata,
    input  logic [addr_w(WORDS)-1:0] i_raddr,
    output logic [DW-1:0]            o_rdata
);

    logic [DW-1:0] r_mem [WORDS];

    // Contents are intentionally never reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo
// Brief   : Single-clock show-ahead FIFO with valid/ready ports, level count
//           and almost-full flag.
// Revision: 1.0 - initial release
// ============================================================================
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DW       = 8,
    parameter int DEPTH    = 16,
    parameter int AFULL_TH = DEPTH - 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DW-1:0]             in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DW-1:0]             out_data,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      afull
);

    localparam int             c_AW       = addr_w(DEPTH);
    localparam int             c_PW       = ptr_w(DEPTH);
    localparam logic [c_PW-1:0] c_ONE      = c_PW'(1);
    localparam logic [c_PW-1:0] c_AFULL_TH = c_PW'(AFULL_TH);

    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_PW-1:0] r_level;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Same address with opposite wrap bits means the writer lapped the reader.
    assign w_full  = (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]) &&
                     (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;

    // Clear conditions dominate, so nothing is stored during rst or flush.
    assign w_push = in_valid && in_ready && !rst && !flush;
    assign w_pop  = out_valid && out_ready && !rst && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ONE;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + c_ONE;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - c_ONE;
            end
        end
    end

    assign level = r_level;
    assign afull = (r_level >= c_AFULL_TH);

    SdpRamRa #(
        .WORDS (DEPTH),
        .DW    (DW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[c_AW-1:0]),
        .i_wdata (in_data),
        .i_raddr (r_rd_ptr[c_AW-1:0]),
        .o_rdata (out_data)
    );

endmodule
`default_nettype wire

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DW, default 8, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of entries; power of two, >= 4.
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-2, level at or above which afull asserts.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port flush  input  1  synchronous clear of contents, same effect as rst on state.
REQ-007 SHALL have port in_valid  input  1  producer has a word on in_data.
REQ-008 SHALL have port in_ready  output  1  FIFO accepts a word this cycle.
REQ-009 SHALL have port in_data  input  DW  write data.
REQ-010 SHALL have port out_valid  output  1  out_data holds the oldest stored word.
REQ-011 SHALL have port out_ready  input  1  consumer takes the word this cycle.
REQ-012 SHALL have port out_data  output  DW  head-of-queue data, show-ahead.
REQ-013 SHALL have port level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 SHALL have port afull  output  1  level >= AFULL_TH.

Function
REQ-015 Push SHALL occur exactly when in_valid && in_ready at a rising edge; pop exactly when out_valid && out_ready.
REQ-016 in_ready SHALL equal (level != DEPTH) and SHALL NOT depend combinationally on out_ready.
REQ-017 out_valid SHALL equal (level != 0) and SHALL NOT depend combinationally on in_valid; no empty bypass.
REQ-018 Write and read pointers SHALL be $clog2(DEPTH)+1 bits; the low bits address storage, the MSB is a wrap flag.
REQ-019 Full SHALL be detected as equal low bits with differing MSB; empty as fully equal pointers.
REQ-020 Pointers SHALL increment modulo 2*DEPTH, with wrap from DEPTH-1 to 0 on the address bits and no skipped or stalled entry.
REQ-021 Write latency SHALL be one cycle: a word pushed at edge N is visible on out_data with out_valid high after edge N when the FIFO was empty.
REQ-022 out_data SHALL be the asynchronous read of storage at the read pointer, and SHALL update in the same cycle the read pointer advances.
REQ-023 Simultaneous push and pop SHALL leave level unchanged and advance both pointers.
REQ-024 Simultaneous push and pop while full SHALL pop only, since in_ready is low.
REQ-025 level SHALL be a registered counter, +1 on push only, -1 on pop only, and SHALL always equal write pointer minus read pointer.
REQ-026 afull SHALL be registered-consistent with level, i.e. derived from the registered level with no extra cycle of lag.
REQ-027 flush SHALL take priority over simultaneous push/pop; words presented in the flush cycle SHALL be discarded.
REQ-028 out_data SHALL be don't-care while out_valid is low, and the bench SHALL NOT check it then.

Reset
REQ-029 On rst or flush, both pointers and level SHALL be 0, out_valid 0, in_ready 1 and afull 0 from the next cycle.
REQ-030 Storage contents SHALL NOT be reset; reset mid-operation SHALL drop all stored words.
REQ-031 While rst is high, no push SHALL be accepted, although in_ready is still driven from state.

Structure
REQ-032 Storage SHALL be one instance of the team's SdpRamRa simple dual-port RAM, asynchronous read, with WORDS=DEPTH; write port on the push, read port on the read pointer.
REQ-033 The pointer width constant and level type derivation SHALL live in a shared package fifo_pkg, with a function for addr width from DEPTH.
REQ-034 There SHALL be no other sub-module; the pointer and flag logic SHALL be inline.

Verification
REQ-035 Reset then push 0x11,0x22,0x33 on consecutive cycles with out_ready=0 -> level 3, out_valid=1, out_data=0x11.
REQ-036 Fill DEPTH=16 words 0x00..0x0F -> in_ready=0 at level 16, afull=1 from level 14; a 17th push with in_valid=1 is ignored.
REQ-037 Full FIFO, in_valid=1 and out_ready=1 for one cycle -> one pop only; level 15; out_data=0x01.
REQ-038 Stream 40 words with in_valid and out_ready both held high, crossing two pointer wraps -> output order equals input order and level stays at most 1.
REQ-039 Hold level 5, then assert flush with push and pop in the same cycle -> next cycle level 0, out_valid=0; push 0xAA -> out_data=0xAA.
REQ-040 Random valid/ready for 10k cycles against a scoreboard queue -> no loss, duplication or reorder, and level always matches the model.
